// File: rtl/serial_negate_pkg.sv
// serial_negate_pkg: shared FSM state type and overflow-pattern helper for the serial negation arbiter
package serial_negate_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction
endpackage

// File: rtl/serial_negate_cell.sv
// serial_negate_cell: 1-bit Mealy two's-complement cell (ports: clk, reset, clear, en, in_bit -> out_bit)
module serial_negate_cell (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic in_bit,
  output logic out_bit
);
  logic seen_one_q, seen_one_d;
  // Bits pass unchanged up to and including the first 1; every later bit is inverted.
  always_comb begin
    seen_one_d = clear ? 1'b0 : (en ? (seen_one_q | in_bit) : seen_one_q);
    out_bit = seen_one_q ? ~in_bit : in_bit;
  end
  always_ff @(posedge clk) seen_one_q <= reset ? 1'b0 : seen_one_d;
endmodule

// File: rtl/serial_negate_arbiter.sv
// serial_negate_arbiter: round-robin shares one bit-serial negation cell among NUM_REQ requesters
//   in : clk, reset, req_valid[NUM_REQ], req_data[NUM_REQ*WIDTH], resp_ready
//   out: req_ready[NUM_REQ] (one-hot, IDLE only), resp_valid, resp_data, resp_id, resp_ovf, busy
module serial_negate_arbiter
  import serial_negate_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_ovf,
  input  logic                     resp_ready,
  output logic                     busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [63:0] MIN_NEG_W = min_neg(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = MIN_NEG_W[WIDTH-1:0];
  // Returns {found, index}; scanning from farthest to nearest lets the nearest valid requester win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid, input logic [ID_W-1:0] ptr);
    logic [ID_W:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) pick = {1'b1, ID_W'(idx)};
    end
    return pick;
  endfunction
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, resp_id_q, resp_id_d, grant;
  logic [WIDTH-1:0] shift_q, shift_d, collect_q, collect_d, resp_data_q, resp_data_d, operand;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic resp_ovf_q, resp_ovf_d;
  logic [ID_W:0] pick;
  logic grant_valid, accept, shifting, last_bit, cell_out;
  serial_negate_cell u_cell (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (shifting),
    .in_bit (shift_q[0]),
    .out_bit(cell_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      shift_q     <= '0;
      collect_q   <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      resp_ovf_q  <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      shift_q     <= shift_d;
      collect_q   <= collect_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_ovf_q  <= resp_ovf_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end
  always_comb begin
    pick        = rr_pick(req_valid, rr_ptr_q);
    grant_valid = pick[ID_W];
    grant       = pick[ID_W-1:0];
    operand     = req_data[int'(grant)*WIDTH +: WIDTH];
    accept      = state_q == IDLE && grant_valid;
    shifting    = state_q == SHIFT;
    last_bit    = bit_cnt_q == CNT_W'(WIDTH - 1);
    state_d     = accept ? SHIFT
                : (shifting && last_bit) ? DONE
                : (state_q == DONE && resp_ready) ? IDLE
                : state_q;
    rr_ptr_d    = accept ? ID_W'((int'(grant) + 1) % NUM_REQ) : rr_ptr_q;
    shift_d     = accept ? operand : (shifting ? shift_q >> 1 : shift_q);
    // Result bits enter at the MSB and drift down, so after WIDTH shifts bit k lands at position k.
    collect_d   = shifting ? {cell_out, collect_q[WIDTH-1:1]} : collect_q;
    // The visible result only updates on the final shift so it stays stable outside DONE.
    resp_data_d = (shifting && last_bit) ? collect_d : resp_data_q;
    resp_id_d   = accept ? grant : resp_id_q;
    resp_ovf_d  = accept ? (operand == MIN_NEG) : resp_ovf_q;
    bit_cnt_d   = accept ? '0 : (shifting ? bit_cnt_q + 1'b1 : bit_cnt_q);
  end
  always_comb begin
    req_ready  = accept ? NUM_REQ'(1) << grant : '0;
    resp_valid = state_q == DONE;
    resp_data  = resp_data_q;
    resp_id    = resp_id_q;
    resp_ovf   = resp_ovf_q;
    busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_serial_negate_arbiter.sv
// tb_serial_negate_arbiter: directed and randomized checks of the serial negation arbiter
module tb_serial_negate_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] a_valid, a_ready;
  logic [15:0] a_data;
  logic [7:0] a_rd;
  logic a_rv, a_id, a_ovf, a_rr, a_busy;
  logic [2:0] b_valid, b_ready;
  logic [47:0] b_data;
  logic [15:0] b_rd;
  logic [1:0] b_id;
  logic b_rv, b_ovf, b_rr, b_busy;
  int checks = 0, errors = 0;
  int mstate, cnt, mptr, ops, cyc, g, idx, r, exp_id;
  int waitc[3];
  logic [15:0] exp_x, x16;
  serial_negate_arbiter #(.WIDTH(8), .NUM_REQ(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .resp_valid(a_rv), .resp_data(a_rd), .resp_id(a_id), .resp_ovf(a_ovf), .resp_ready(a_rr), .busy(a_busy)
  );
  serial_negate_arbiter #(.WIDTH(16), .NUM_REQ(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .resp_valid(b_rv), .resp_data(b_rd), .resp_id(b_id), .resp_ovf(b_ovf), .resp_ready(b_rr), .busy(b_busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] neg_ref(input longint x, input int w);
    longint m;
    m = longint'(1) << w;
    return 32'((m - x) % m);
  endfunction
  task automatic start_a(input logic [1:0] vmask, input int gi, input logic keep);
    a_valid = vmask;
    #1;
    check("req_ready", 32'(a_ready), 32'(1 << gi));
    tick;
    if (!keep) a_valid = 2'b00;
  endtask
  task automatic wait_a(input logic [7:0] x, input int gi);
    int n;
    n = 0;
    while (!a_rv && n < 40) begin
      tick;
      n++;
    end
    check("latency", n, 8);
    check("resp_data", 32'(a_rd), neg_ref(longint'(x), 8));
    check("resp_id", 32'(a_id), gi);
    check("resp_ovf", 32'(a_ovf), 32'(x == 8'h80));
    check("busy_done", 32'(a_busy), 1);
  endtask
  task automatic hs_a;
    a_rr = 1'b1;
    tick;
    check("resp_valid_drop", 32'(a_rv), 0);
    check("busy_idle", 32'(a_busy), 0);
  endtask
  task automatic op_a(input int gi, input logic [7:0] x);
    a_data[gi*8 +: 8] = x;
    start_a(2'(1 << gi), gi, 1'b0);
    wait_a(x, gi);
    hs_a;
  endtask
  initial begin
    logic [7:0] bnd [4];
    bnd = '{8'h00, 8'h80, 8'hFF, 8'h01};
    a_valid = '0; a_data = '0; a_rr = 1'b1;
    b_valid = '0; b_data = '0; b_rr = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    check("rst_req_ready", 32'(a_ready), 0);
    check("rst_resp_valid", 32'(a_rv), 0);
    check("rst_resp_data", 32'(a_rd), 0);
    check("rst_resp_id", 32'(a_id), 0);
    check("rst_resp_ovf", 32'(a_ovf), 0);
    check("rst_busy", 32'(a_busy), 0);
    op_a(0, 8'h05);
    for (int i = 0; i < 4; i++) op_a(0, bnd[i]);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    a_data = {8'h22, 8'h10};
    for (int k = 0; k < 4; k++) begin
      start_a(2'b11, k % 2, 1'b1);
      wait_a((k % 2) != 0 ? 8'h22 : 8'h10, k % 2);
      hs_a;
    end
    a_valid = 2'b00;
    a_rr = 1'b0;
    a_data[7:0] = 8'h33;
    start_a(2'b01, 0, 1'b0);
    a_valid = 2'b10;
    wait_a(8'h33, 0);
    for (int i = 0; i < 20; i++) begin
      tick;
      check("hold_valid", 32'(a_rv), 1);
      check("hold_data", 32'(a_rd), neg_ref(64'h33, 8));
      check("hold_ready", 32'(a_ready), 0);
    end
    a_rr = 1'b1;
    tick;
    check("release_valid", 32'(a_rv), 0);
    start_a(2'b10, 1, 1'b0);
    wait_a(8'h22, 1);
    hs_a;
    a_data[7:0] = 8'h0F;
    start_a(2'b01, 0, 1'b0);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", 32'(a_busy), 0);
    check("abort_valid", 32'(a_rv), 0);
    a_data[7:0] = 8'h7F;
    start_a(2'b11, 0, 1'b0);
    wait_a(8'h7F, 0);
    hs_a;
    mstate = 0; cnt = 0; mptr = 0; ops = 0; cyc = 0;
    for (int i = 0; i < 3; i++) waitc[i] = 0;
    while (ops < 1000 && cyc < 60000) begin
      for (int i = 0; i < 3; i++)
        if (!b_valid[i] && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 9);
          x16 = r == 0 ? 16'h8000 : r == 1 ? 16'h0000 : r == 2 ? 16'hFFFF : 16'($urandom);
          b_valid[i] = 1'b1;
          b_data[i*16 +: 16] = x16;
          waitc[i] = 0;
        end
      b_rr = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (mstate == 0)
        for (int k = 2; k >= 0; k--) begin
          idx = (mptr + k) % 3;
          if (b_valid[idx]) g = idx;
        end
      check("b_req_ready", 32'(b_ready), g >= 0 ? 32'(1 << g) : 0);
      check("b_resp_valid", 32'(b_rv), 32'(mstate == 2));
      if (mstate == 2) begin
        check("b_resp_data", 32'(b_rd), neg_ref(longint'(exp_x), 16));
        check("b_resp_id", 32'(b_id), exp_id);
        check("b_resp_ovf", 32'(b_ovf), 32'(exp_x == 16'h8000));
      end
      tick;
      cyc++;
      if (g >= 0) begin
        check("b_starvation", 32'(waitc[g] <= 2), 1);
        for (int i = 0; i < 3; i++) if (i != g && b_valid[i]) waitc[i]++;
        exp_x = b_data[g*16 +: 16];
        exp_id = g;
        mptr = (g + 1) % 3;
        b_valid[g] = 1'b0;
        mstate = 1;
        cnt = 16;
      end else if (mstate == 1) begin
        cnt--;
        if (cnt == 0) mstate = 2;
      end else if (mstate == 2 && b_rr) begin
        mstate = 0;
        ops++;
      end
    end
    check("b_ops_done", ops, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
